normalizer: RTL
===============

# normalizer

Multi-cycle leading-zero normalizer for the datapath. It is the inverse companion of the combinational shifter. Instead of shifting by a given distance, it finds the distance: it left-shifts an operand until its MSB is 1 and reports how many positions it moved. The floating-point pack/round stages use it to renormalize mantissas after subtraction. It connects through a valid/ready handshake on both sides.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 8.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand present on in_value.
- in_ready  out  1  block can accept an operand.
- in_value  in  WIDTH  operand, treated as unsigned bit pattern.
- out_valid  out  1  result present on out_value/out_shift/out_zero.
- out_ready  in  1  consumer takes the result.
- out_value  out  WIDTH  normalized operand (MSB = 1 unless zero).
- out_shift  out  $clog2(WIDTH)+1  left-shift count applied, 0..WIDTH.
- out_zero  out  1  operand was all zeros.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- In IDLE:
  - in_ready = 1.
  - On in_valid && in_ready (acceptance edge E0): load in_value into the work register, clear the count, and go to SHIFT.
- In SHIFT, evaluated at each rising edge:
  - Work register == 0: go to DONE with out_value = 0, out_shift = WIDTH, out_zero = 1.
  - Else if MSB == 1: go to DONE with out_value = work register, out_shift = count, out_zero = 0.
  - Else: shift the work register left by 1 with zero fill, count += 1, and stay in SHIFT.
- In DONE:
  - out_valid = 1; all outputs stay frozen until out_valid && out_ready.
  - On that handshake edge: return to IDLE and drop out_valid.
- in_ready is 1 only in IDLE, so IDLE and DONE never overlap.
  - A new operand cannot be accepted in the same cycle the result is taken.
  - in_valid is ignored in SHIFT and DONE.
- in_value is sampled only at E0; later changes have no effect.
- All outputs are driven from registers; there is no combinational path from an input to an output.
- Count arithmetic is unsigned and never exceeds WIDTH-1 while in SHIFT; out_shift = WIDTH only for the zero case.

## Timing
- Reset (rst_n low, asynchronous, takes effect at any point including mid-SHIFT or DONE):
  - State → IDLE.
  - out_valid = 0, out_value = 0, out_shift = 0, out_zero = 0.
  - in_ready = 1 while in reset and after release.
- Acceptance: in_ready is low in the cycle after E0.
- Latency, for an operand with k leading zeros (0 ≤ k < WIDTH):
  - Macro off: out_valid rises after edge E(k+1).
  - Zero operand: out_valid rises after E1.
- Throughput: one operand per (latency + 2) cycles when out_ready is held high. This is one DONE cycle plus one IDLE cycle.

## Configuration
- NORMALIZER_NIBBLE_EN, when defined:
  - In SHIFT, if the work register is nonzero and its top 4 bits are zero, shift left by 4 and count += 4 in one edge.
  - Otherwise behave as above.
  - Latency for k leading zeros becomes floor(k/4) + (k mod 4) + 1 edges after E0. The zero case stays at E1.
  - Results are bit-identical to macro-off.
- When undefined: 1 bit per edge only; no 4-bit shift logic is synthesized.

## Test plan
- Reset: assert rst_n low while in SHIFT with operand 16'h0001 → out_valid = 0 and all outputs 0 immediately; in_ready = 1 after release; a following operand is processed normally.
- 16'h8000 → out_value 16'h8000, out_shift 0, out_zero 0, out_valid after E1.
- 16'h0001 → out_value 16'h8000, out_shift 15; out_valid after E16 with the macro off, E7 with NORMALIZER_NIBBLE_EN.
- 16'h0000 → out_value 0, out_shift 16, out_zero 1, out_valid after E1 in both configurations.
- 16'h0B6D with out_ready held low for 5 cycles after out_valid, and in_valid pulsed with 16'hFFFF meanwhile:
  - out_value 16'hB6D0 and out_shift 4 are held stable for all 5 cycles.
  - in_ready stays 0; the pulsed operand is ignored.
  - The handshake returns the block to IDLE.
- Back-to-back, in_valid and out_ready tied high, operands 16'h4000 then 16'h0010:
  - Results out_shift 1 then 11.
  - Second acceptance occurs exactly one cycle after the first result handshake.

Source files
------------

// File: rtl/normalizer.sv
// Multi-cycle leading-zero normalizer: shifts an operand left until its MSB is set and reports the distance.
// Optional NORMALIZER_NIBBLE_EN adds a 4-bit skip step for a leading zero nibble; results are identical either way.
module normalizer #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_value,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_value,
  output logic [$clog2(WIDTH):0]     out_shift,
  output logic                       out_zero
);

  localparam int SW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic             zero_q, zero_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      shift_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      shift_q <= shift_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    shift_d = shift_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_value;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (work_q == '0) begin
          value_d = '0;
          shift_d = SW'(WIDTH);
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (work_q[WIDTH-1]) begin
          value_d = work_q;
          shift_d = cnt_q;
          zero_d  = 1'b0;
          state_d = DONE;
`ifdef NORMALIZER_NIBBLE_EN
        end else if (work_q[WIDTH-1 -: 4] == 4'b0000) begin
          // Nonzero with an empty top nibble: at least 4 more shifts are guaranteed.
          work_d = {work_q[WIDTH-5:0], 4'b0000};
          cnt_d  = cnt_q + SW'(4);
`endif
        end else begin
          work_d = {work_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + SW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_value = value_q;
  assign out_shift = shift_q;
  assign out_zero  = zero_q;

endmodule
